// File: rtl/spi_msg_responder.sv
// SPI slave responder: plays back a host-writable word table or echoes the previous frame,
// and captures every received word into ping-pong banks. Includes the spiSlave shift core.

module spiSlave #(
  parameter int unsigned DATA_WDT = 8,
  parameter logic        CPOL     = 1'b1,
  parameter logic        CPHA     = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ssel,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  output logic                spiStart,
  output logic                spiTxLoad,
  output logic                spiEnd,
  input  logic [DATA_WDT-1:0] spiTxData,
  output logic [DATA_WDT-1:0] spiRxData
);

  localparam int unsigned BW = $clog2(DATA_WDT);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WDT - 1);

  logic [2:0]          ssel_sync;
  logic [2:0]          sclk_sync;
  logic [1:0]          mosi_sync;
  logic [BW-1:0]       bit_cnt_q;
  logic [DATA_WDT-1:0] tx_sr_q;
  logic [DATA_WDT-2:0] rx_sr_q;
  logic [DATA_WDT-1:0] rxd_q;
  logic [1:0]          load_pend_q;
  logic                start_q;
  logic                end_q;

  logic                start_edge;
  logic                sclk_rise;
  logic                sclk_fall;
  logic                shift_edge;
  logic                samp_edge;
  logic [DATA_WDT-1:0] rx_next;

  always_comb begin
    start_edge = ssel_sync[2] & ~ssel_sync[1];
    sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
    sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
    // Leading edge leaves the idle level; CPHA picks which edge shifts and which samples.
    if (CPHA) begin
      shift_edge = (CPOL ? sclk_fall : sclk_rise) & ~ssel_sync[1];
      samp_edge  = (CPOL ? sclk_rise : sclk_fall) & ~ssel_sync[1];
    end else begin
      shift_edge = (CPOL ? sclk_rise : sclk_fall) & ~ssel_sync[1];
      samp_edge  = (CPOL ? sclk_fall : sclk_rise) & ~ssel_sync[1];
    end
    rx_next = {rx_sr_q, mosi_sync[1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssel_sync   <= 3'b111;
      sclk_sync   <= {3{CPOL}};
      mosi_sync   <= 2'b00;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rxd_q       <= '0;
      load_pend_q <= 2'b00;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      ssel_sync   <= {ssel_sync[1:0], ssel};
      sclk_sync   <= {sclk_sync[1:0], sclk};
      mosi_sync   <= {mosi_sync[0], mosi};
      start_q     <= start_edge;
      end_q       <= 1'b0;
      // With CPHA=0 the first bit must be on miso before the first edge; the word
      // presented for spiStart is ready two cycles after the start edge.
      load_pend_q <= {load_pend_q[0], start_edge & ~CPHA};
      if (start_edge) begin
        bit_cnt_q <= '0;
      end else begin
        if (load_pend_q[1]) begin
          tx_sr_q <= spiTxData;
        end else if (shift_edge) begin
          tx_sr_q <= (bit_cnt_q == '0) ? spiTxData : {tx_sr_q[DATA_WDT-2:0], 1'b0};
        end
        if (samp_edge) begin
          rx_sr_q <= rx_next[DATA_WDT-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q <= '0;
            end_q     <= 1'b1;
            rxd_q     <= rx_next;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign miso      = tx_sr_q[DATA_WDT-1];
  assign spiStart  = start_q;
  assign spiTxLoad = end_q;
  assign spiEnd    = end_q;
  assign spiRxData = rxd_q;

endmodule

module spi_msg_responder #(
  parameter int unsigned DATA_WDT = 8,
  parameter int unsigned DEPTH    = 4,
  parameter logic        CPOL     = 1'b1,
  parameter logic        CPHA     = 1'b1,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ssel,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  input  logic                mode,
  input  logic                tbl_we,
  input  logic [AW-1:0]       tbl_addr,
  input  logic [DATA_WDT-1:0] tbl_wdata,
  input  logic                ovr_clr,
  output logic                rx_valid,
  output logic [DATA_WDT-1:0] rx_data,
  output logic [AW:0]         rx_index,
  output logic                busy,
  output logic                frame_done,
  output logic [AW:0]         frame_len,
  output logic                overrun
);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic                spi_start;
  logic                spi_tx_load;
  logic                spi_end;
  logic [DATA_WDT-1:0] spi_rx_data;

  logic [DATA_WDT-1:0] tbl_q [DEPTH];
  logic [DATA_WDT-1:0] cap_q [2][DEPTH];
  logic                cap_sel_q;
  logic                ebank_q;
  logic                mode_q;
  logic [AW-1:0]       tx_ptr_q;
  logic [DATA_WDT-1:0] tx_data_q;
  logic [AW:0]         rx_cnt_q;
  logic                rx_valid_q;
  logic [DATA_WDT-1:0] rx_data_q;
  logic [AW:0]         rx_index_q;
  logic                overrun_q;
  logic [2:0]          ssel_sync;
  logic                frame_done_q;
  logic [AW:0]         frame_len_q;

  logic                frame_edge;
  logic                swap;
  logic                ebank_new;
  logic                ld_mode;
  logic                ld_bank;
  logic [AW-1:0]       ld_idx;
  logic [DATA_WDT-1:0] ld_word;
  logic [AW-1:0]       ptr_next;
  logic [AW:0]         cnt_base;
  logic                cnt_ok;
  logic                tbl_addr_ok;

  spiSlave #(
    .DATA_WDT (DATA_WDT),
    .CPOL     (CPOL),
    .CPHA     (CPHA)
  ) u_spi_slave (
    .clk       (clk),
    .reset     (reset),
    .ssel      (ssel),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .spiStart  (spi_start),
    .spiTxLoad (spi_tx_load),
    .spiEnd    (spi_end),
    .spiTxData (tx_data_q),
    .spiRxData (spi_rx_data)
  );

  always_comb begin
    frame_edge = ssel_sync[1] & ~ssel_sync[2];
    swap       = frame_edge && (rx_cnt_q != '0);
    // A start coinciding with the swap already sees the freshly filled bank as echo source.
    ebank_new  = swap ? cap_sel_q : ~cap_sel_q;
    if (spi_start) begin
      ld_mode = mode;
      ld_bank = ebank_new;
      ld_idx  = '0;
    end else begin
      ld_mode = mode_q;
      ld_bank = ebank_q;
      ld_idx  = tx_ptr_q;
    end
    ld_word     = ld_mode ? cap_q[ld_bank][ld_idx] : tbl_q[ld_idx];
    ptr_next    = (ld_idx == LAST_PTR) ? '0 : ld_idx + 1'b1;
    cnt_base    = spi_start ? '0 : rx_cnt_q;
    cnt_ok      = cnt_base < DEPTH_C;
    tbl_addr_ok = {1'b0, tbl_addr} < DEPTH_C;
  end

  // Table: loads read the registered value, so a same-cycle write is seen by the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) tbl_q[k] <= DATA_WDT'(k);
    end else if (tbl_we && tbl_addr_ok) begin
      tbl_q[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_q <= '0;
      tx_ptr_q  <= '0;
      mode_q    <= 1'b0;
      ebank_q   <= 1'b1;
    end else if (spi_start) begin
      tx_data_q <= ld_word;
      tx_ptr_q  <= ptr_next;
      mode_q    <= mode;
      ebank_q   <= ebank_new;
    end else if (spi_tx_load) begin
      tx_data_q <= ld_word;
      tx_ptr_q  <= ptr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < DEPTH; k++) cap_q[b][k] <= '0;
      end
      rx_cnt_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_index_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= spi_end;
      if (spi_end) begin
        rx_data_q  <= spi_rx_data;
        rx_index_q <= cnt_base;
        if (cnt_ok) begin
          cap_q[cap_sel_q][cnt_base[AW-1:0]] <= spi_rx_data;
          rx_cnt_q <= cnt_base + 1'b1;
        end else begin
          rx_cnt_q <= cnt_base;
        end
      end else if (spi_start) begin
        rx_cnt_q <= '0;
      end
      if (spi_end && !cnt_ok) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssel_sync    <= 3'b111;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      cap_sel_q    <= 1'b0;
    end else begin
      ssel_sync    <= {ssel_sync[1:0], ssel};
      frame_done_q <= frame_edge;
      if (frame_edge) begin
        frame_len_q <= rx_cnt_q;
      end
      // An empty frame keeps the previous echo content.
      if (swap) begin
        cap_sel_q <= ~cap_sel_q;
      end
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_index   = rx_index_q;
  assign busy       = ~ssel_sync[1];
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_msg_responder.sv
// Directed bench for spi_msg_responder: a default 8-bit/4-deep instance and a 16-bit/8-deep
// instance share the SPI pins; a bit-banged mode-3 master drives frames.

module tb_spi_msg_responder;

  logic        clk;
  logic        reset;
  logic        ssel;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        mode;
  logic        tbl_we;
  logic [1:0]  tbl_addr;
  logic [7:0]  tbl_wdata;
  logic        ovr_clr;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [2:0]  rx_index;
  logic        busy;
  logic        frame_done;
  logic [2:0]  frame_len;
  logic        overrun;

  logic        miso16;
  logic        mode16;
  logic        tbl_we16;
  logic [2:0]  tbl_addr16;
  logic [15:0] tbl_wdata16;
  logic        ovr_clr16;
  logic        rx_valid16;
  logic [15:0] rx_data16;
  logic [3:0]  rx_index16;
  logic        busy16;
  logic        frame_done16;
  logic [3:0]  frame_len16;
  logic        overrun16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mtx [16];
  logic [15:0] mrx [16];
  logic [15:0] rq_d [$];
  logic [3:0]  rq_i [$];
  int          fd_cnt = 0;
  int          fd_len = 0;
  int          fd16_cnt = 0;
  int          fd16_len = 0;
  int          rx16_cnt = 0;
  int          rx16_last_idx = 0;
  logic [15:0] rx16_last_data = '0;
  int          hook_w = -1;
  int          fd_before;

  spi_msg_responder u_dut (
    .clk        (clk),
    .reset      (reset),
    .ssel       (ssel),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .mode       (mode),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .ovr_clr    (ovr_clr),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_index   (rx_index),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .overrun    (overrun)
  );

  spi_msg_responder #(
    .DATA_WDT (16),
    .DEPTH    (8)
  ) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .ssel       (ssel),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso16),
    .mode       (mode16),
    .tbl_we     (tbl_we16),
    .tbl_addr   (tbl_addr16),
    .tbl_wdata  (tbl_wdata16),
    .ovr_clr    (ovr_clr16),
    .rx_valid   (rx_valid16),
    .rx_data    (rx_data16),
    .rx_index   (rx_index16),
    .busy       (busy16),
    .frame_done (frame_done16),
    .frame_len  (frame_len16),
    .overrun    (overrun16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rq_d.push_back({8'h00, rx_data});
      rq_i.push_back({1'b0, rx_index});
    end
    if (frame_done) begin
      fd_cnt++;
      fd_len = int'(frame_len);
    end
    if (rx_valid16) begin
      rx16_cnt++;
      rx16_last_idx  = int'(rx_index16);
      rx16_last_data = rx_data16;
    end
    if (frame_done16) begin
      fd16_cnt++;
      fd16_len = int'(frame_len16);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half_sclk();
    repeat (8) @(negedge clk);
  endtask

  task automatic tbl_write(input logic [1:0] a, input logic [7:0] d);
    tbl_we    = 1'b1;
    tbl_addr  = a;
    tbl_wdata = d;
    @(negedge clk);
    tbl_we    = 1'b0;
  endtask

  task automatic send_word(input int w, input logic [15:0] d, output logic [15:0] r);
    r = '0;
    for (int b = w - 1; b >= 0; b--) begin
      sclk = 1'b0;
      mosi = d[b];
      half_sclk();
      r[b] = (w == 16) ? miso16 : miso;
      sclk = 1'b1;
      half_sclk();
    end
  endtask

  task automatic do_frame(input int n, input int w);
    rq_d.delete();
    rq_i.delete();
    ssel = 1'b0;
    half_sclk();
    check("busy_in_frame", 32'(busy), 1);
    for (int i = 0; i < n; i++) begin
      if (i == hook_w) begin
        tbl_write(2'd2, 8'h5A);
        tbl_write(2'd0, 8'h77);
      end
      send_word(w, mtx[i], mrx[i]);
    end
    ssel = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ssel = 1'b1; sclk = 1'b1; mosi = 1'b0; mode = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0; ovr_clr = 1'b0;
    mode16 = 1'b0; tbl_we16 = 1'b0; tbl_addr16 = '0; tbl_wdata16 = '0; ovr_clr16 = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_index", 32'(rx_index), 0);
    check("rst_frame_len", 32'(frame_len), 0);
    check("rst_miso", 32'(miso), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Default table playback
    mtx[0] = 16'hC1; mtx[1] = 16'h5E; mtx[2] = 16'h00; mtx[3] = 16'hFF;
    fd_before = fd_cnt;
    do_frame(4, 8);
    for (int i = 0; i < 4; i++) check($sformatf("t1_miso%0d", i), 32'(mrx[i]), i);
    check("t1_rx_count", rq_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_rx_data%0d", i), 32'(rq_d[i]), 32'(mtx[i]));
      check($sformatf("t1_rx_index%0d", i), 32'(rq_i[i]), i);
    end
    check("t1_fd_pulses", fd_cnt - fd_before, 1);
    check("t1_frame_len", fd_len, 4);
    check("t1_overrun", 32'(overrun), 0);
    check("t1_busy_idle", 32'(busy), 0);

    // Written table, 6-word frame wraps and overruns
    tbl_write(2'd0, 8'hA2); tbl_write(2'd1, 8'h37);
    tbl_write(2'd2, 8'h27); tbl_write(2'd3, 8'hF5);
    for (int i = 0; i < 6; i++) mtx[i] = 16'(8'h10 + i);
    fd_before = fd_cnt;
    do_frame(6, 8);
    check("t2_miso0", 32'(mrx[0]), 32'h A2);
    check("t2_miso1", 32'(mrx[1]), 32'h37);
    check("t2_miso2", 32'(mrx[2]), 32'h27);
    check("t2_miso3", 32'(mrx[3]), 32'hF5);
    check("t2_miso4", 32'(mrx[4]), 32'hA2);
    check("t2_miso5", 32'(mrx[5]), 32'h37);
    check("t2_rx_index4", 32'(rq_i[4]), 4);
    check("t2_rx_index5", 32'(rq_i[5]), 4);
    check("t2_frame_len", fd_len, 4);
    check("t2_overrun", 32'(overrun), 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    @(negedge clk);
    check("t2_ovr_clr", 32'(overrun), 0);

    // Echo mode starting from fresh banks
    pulse_reset();
    mode = 1'b1;
    mtx[0] = 16'h11; mtx[1] = 16'h22; mtx[2] = 16'h33;
    do_frame(3, 8);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3a_miso%0d", i), 32'(mrx[i]), 0);
      check($sformatf("t3a_rx_index%0d", i), 32'(rq_i[i]), i);
    end
    check("t3a_rx_count", rq_d.size(), 3);
    check("t3a_frame_len", fd_len, 3);
    fd_before = fd_cnt;
    do_frame(0, 8);
    check("t3b_fd_pulses", fd_cnt - fd_before, 1);
    check("t3b_frame_len", fd_len, 0);
    mtx[0] = 16'hAA; mtx[1] = 16'hBB; mtx[2] = 16'hCC; mtx[3] = 16'hDD;
    do_frame(4, 8);
    check("t3c_miso0", 32'(mrx[0]), 32'h11);
    check("t3c_miso1", 32'(mrx[1]), 32'h22);
    check("t3c_miso2", 32'(mrx[2]), 32'h33);
    check("t3c_miso3", 32'(mrx[3]), 32'h00);
    mode = 1'b0;

    // Mid-frame table writes (word 2 affected now, word 0 only next frame)
    hook_w = 1;
    do_frame(4, 8);
    hook_w = -1;
    check("t4a_miso0", 32'(mrx[0]), 32'h00);
    check("t4a_miso1", 32'(mrx[1]), 32'h01);
    check("t4a_miso2", 32'(mrx[2]), 32'h5A);
    check("t4a_miso3", 32'(mrx[3]), 32'h03);
    do_frame(4, 8);
    check("t4b_miso0", 32'(mrx[0]), 32'h77);
    check("t4b_miso1", 32'(mrx[1]), 32'h01);
    check("t4b_miso2", 32'(mrx[2]), 32'h5A);
    check("t4b_miso3", 32'(mrx[3]), 32'h03);

    // Reset after two words of a frame
    ssel = 1'b0;
    half_sclk();
    send_word(8, 16'h81, mrx[0]);
    send_word(8, 16'h42, mrx[1]);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rx_valid", 32'(rx_valid), 0);
    check("t5_rx_data", 32'(rx_data), 0);
    check("t5_rx_index", 32'(rx_index), 0);
    check("t5_frame_len", 32'(frame_len), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_miso", 32'(miso), 0);
    reset = 1'b0;
    @(negedge clk);
    check("t5_busy_1clk", 32'(busy), 0);
    @(negedge clk);
    check("t5_busy_2clk", 32'(busy), 1);
    fd_before = fd_cnt;
    ssel = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_fd_pulses", fd_cnt - fd_before, 1);
    check("t5_fd_len", fd_len, 0);
    do_frame(4, 8);
    for (int i = 0; i < 4; i++) check($sformatf("t5_tbl_revert%0d", i), 32'(mrx[i]), i);

    // 16-bit, 8-deep instance: playback, wrap on word 9, overrun
    pulse_reset();
    for (int i = 0; i < 9; i++) mtx[i] = 16'(16'h1234 + 16'h1111 * i);
    fd_before = fd16_cnt;
    rx16_cnt  = 0;
    do_frame(9, 16);
    for (int i = 0; i < 8; i++) check($sformatf("t6_miso%0d", i), 32'(mrx[i]), i);
    check("t6_miso_wrap", 32'(mrx[8]), 0);
    check("t6_fd_pulses", fd16_cnt - fd_before, 1);
    check("t6_frame_len", fd16_len, 8);
    check("t6_overrun", 32'(overrun16), 1);
    check("t6_rx_count", rx16_cnt, 9);
    check("t6_rx_last_idx", rx16_last_idx, 8);
    check("t6_rx_last_data", 32'(rx16_last_data), 32'(mtx[8]));
    check("t6_busy_idle", 32'(busy16), 0);
    ovr_clr16 = 1'b1;
    @(negedge clk);
    ovr_clr16 = 1'b0;
    @(negedge clk);
    check("t6_ovr_clr", 32'(overrun16), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_msg_responder.md
# spi_msg_responder

Parametrised SPI slave responder for board-level SPI bring-up and link checking. It wraps the codebase `spiSlave` core and plays back a host-writable table of `DEPTH` words of `DATA_WDT` bits per frame. It captures every received word and can optionally echo the previous frame back to the master. It sits between the board SPI pins and the FPGA-side host logic (status LEDs, table loader, debug bus).

## Interface
Parameters:
- `DATA_WDT`, 8: SPI word width; passed to `spiSlave`.
- `DEPTH`, 4: words per table and per capture bank; must be ≥ 2.
- `CPOL`, 1'b1: clock polarity; passed to `spiSlave`.
- `CPHA`, 1'b1: clock phase; passed to `spiSlave`.
- `AW`, $clog2(DEPTH): derived address width; not overridden.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ssel` in 1: active-low slave select, asynchronous to `clk`.
- `sclk` in 1: SPI clock.
- `mosi` in 1: master-out data.
- `miso` out 1: master-in data, driven by `spiSlave`.
- `mode` in 1: 0 = table playback, 1 = echo previous frame.
- `tbl_we` in 1: table write strobe.
- `tbl_addr` in AW: table write address.
- `tbl_wdata` in DATA_WDT: table write data.
- `ovr_clr` in 1: clears `overrun`.
- `rx_valid` out 1: one-cycle pulse; a word was received.
- `rx_data` out DATA_WDT: received word, valid with `rx_valid`.
- `rx_index` out AW+1: position of the word in the frame, 0-based, saturating at DEPTH.
- `busy` out 1: synchronized `ssel` is low.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `frame_len` out AW+1: words received in the last frame, saturating at DEPTH. Updated with `frame_done`.
- `overrun` out 1: sticky; a frame had more than DEPTH words.

## Operation
- `spiSlave` handshake:
  - `spiStart` pulses once at frame start.
  - `spiTxLoad` pulses when the next tx word must be presented.
  - `spiEnd` pulses when `spiRxData` holds a complete received word.
- TX pointer `tx_ptr` (AW bits):
  - On `spiStart`: present word 0 on `spiTxData` and set `tx_ptr` = 1.
  - On `spiTxLoad`: present word[`tx_ptr`] and increment `tx_ptr` modulo DEPTH. Frames longer than DEPTH replay from word 0.
- Source selection: `mode` is sampled at `spiStart` into `mode_q`. Changes to `mode` mid-frame are ignored.
  - `mode_q` = 0: words come from the table.
  - `mode_q` = 1: words come from the echo bank.
- Table:
  - DEPTH × DATA_WDT registers. Reset content is word k = k.
  - `tbl_we` writes `tbl_addr` on the same clk edge. Writes are allowed mid-frame and affect only words loaded after the write edge.
  - If a write and a load hit the same address on the same cycle, the load gets the old value.
- Capture: two banks, A and B, DEPTH words each, reset to 0. One bank is the capture bank and the other is the echo bank; after reset, A captures.
  - On `spiEnd` with `rx_cnt` < DEPTH: write `spiRxData` into capture[`rx_cnt`].
  - `rx_cnt` increments on every `spiEnd` and saturates at DEPTH.
  - On `spiEnd` with `rx_cnt` = DEPTH: the word is not stored and `overrun` is set.
  - `rx_cnt` clears on `spiStart`.
- Frame end is detected as the rising edge of `ssel` after a 2-FF synchronizer. On that edge:
  - `frame_done` pulses.
  - `frame_len` is set to `rx_cnt`.
  - If `rx_cnt` > 0, the capture and echo banks swap. A zero-word frame leaves the echo bank unchanged.
- Simultaneous events:
  - `spiStart` and `spiTxLoad` together: `spiStart` wins.
  - `spiStart` and `spiEnd` together: the count clears, then the word is stored at index 0 with `rx_cnt` = 1.
  - `ovr_clr` and a new overrun together: the set wins.
- Reset mid-frame: all state returns to reset values, including table content and bank selection. The synchronizer resets to idle (1).
  - If `ssel` is low at reset release, `busy` rises after 2 cycles.
  - The subsequent rising edge of `ssel` produces `frame_done` with the count accumulated since reset.
  - The next `spiStart` resynchronizes the tx pointer.

## Timing
- Reset values:
  - `rx_valid`, `frame_done`, `overrun`: 0.
  - `busy`: 0.
  - `rx_data`, `rx_index`, `frame_len`: 0.
  - `spiTxData`: table word 0 (= 0).
  - `miso`: reset value of `spiSlave`.
- `spiTxData` is registered and valid on the clk after `spiStart`/`spiTxLoad`. The design is supported for sclk ≤ clk/8.
- `rx_valid`, `rx_data`, `rx_index` are registered, 1 clk after `spiEnd`. `rx_index` carries the pre-increment `rx_cnt`.
- `busy` follows `ssel` with 2–3 clk latency.
- `frame_done` comes 3 clk after `ssel` rises (2 sync + edge register). `frame_len` and the bank swap become visible in the same cycle.
- Echo source:
  - The echo bank in use for a frame is the one selected at its `spiStart`.
  - A swap requires ≥ 1 clk between `frame_done` and the next `spiStart`.
  - If `spiStart` falls in the same cycle as the swap, the new bank is used.

## Test plan
- Reset, then a 4-word frame in mode 0 with default params -> `miso` carries 0x00, 0x01, 0x02, 0x03. Afterwards: `frame_done` pulse, `frame_len` = 4, `overrun` = 0.
- Write table {0xA2, 0x37, 0x27, 0xF5}, then a 6-word frame -> tx sequence A2, 37, 27, F5, A2, 37. Afterwards: `frame_len` = 4 (saturated), `overrun` = 1. `ovr_clr` -> `overrun` = 0.
- Mode 1:
  - Frame 1: master sends 0x11, 0x22, 0x33 -> `rx_valid` ×3 with `rx_index` 0, 1, 2.
  - Frame 2: `miso` returns 0x11, 0x22, 0x33, 0x00.
  - A zero-word frame in between leaves the echo bank unchanged.
- Mid-frame table write of word 2 to 0x5A after word 1 is loaded -> word 2 of that frame is 0x5A. Write of word 0 during the same frame -> affects only the next frame.
- Assert reset after 2 words of a frame -> all outputs return to reset values and the table reverts to k. After `ssel` rises, `frame_done` pulses with `frame_len` = 0 if no words followed the reset.
- DATA_WDT = 16, DEPTH = 8 -> 8-word playback of 0x0000..0x0007, then wrap to 0x0000 on word 9, with `frame_len` = 8 and `overrun` = 1.
